nios2_ocimem_arbiter: RTL and testbench
=======================================

Name: nios2_ocimem_arbiter

Overview:
- Sysclk-domain controller for the Nios II on-chip debug memory (OCI RAM, single-port, 1-cycle read latency).
- Shares the RAM between two requesters:
  - the CPU's Avalon-MM debug-memory slave port;
  - JTAG debug commands, which arrive as take_action/take_no_action strobes plus the 38-bit jdo word from the debug-slave sysclk block.
- Sequences JTAG reads and writes with auto-incrementing address, returns read data on MonDReg, and arbitrates with fixed JTAG priority.

Parameters:
- ADDR_W, 8, RAM word-address width (max 10); depth = 2^ADDR_W words of 32 bits.
- WP_BASE, 8'hC0, first word address of the CPU write-protected region (used only with OCIMEM_CPU_WP_EN).

Ports:
- clk  input  1  system clock; everything in this block is synchronous to it.
- reset  input  1  synchronous, active-high reset.
- jdo  input  38  JTAG data word from the debug slave, valid while any strobe is high.
- take_action_ocimem_a  input  1  JTAG address-load strobe (1-cycle pulse).
- take_no_action_ocimem_a  input  1  JTAG read-at-current-address strobe.
- take_action_ocimem_b  input  1  JTAG write strobe.
- cpu_address  input  ADDR_W  CPU word address.
- cpu_read  input  1  CPU read request.
- cpu_write  input  1  CPU write request.
- cpu_writedata  input  32  CPU write data.
- cpu_byteenable  input  4  CPU byte enables.
- cpu_waitrequest  output  1  Avalon waitrequest.
- cpu_readdata  output  32  CPU read data.
- cpu_readdatavalid  output  1  CPU read data valid, 1-cycle pulse.
- cpu_wp_err  output  1  CPU write-protect violation pulse (optional feature).
- ram_addr  output  ADDR_W  RAM address.
- ram_wren  output  1  RAM write enable.
- ram_byteen  output  4  RAM byte enables.
- ram_wdata  output  32  RAM write data.
- ram_rdata  input  32  RAM read data, valid one cycle after address.
- MonDReg  output  32  last JTAG read data, or last JTAG write data.
- jtag_cmd_err  output  1  sticky error: JTAG command dropped.

Behaviour:

Clocking and reset:
- All logic is clocked by clk. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE; jtag_addr = 0; pending slot empty;
  - MonDReg = 0; cpu_readdata = 0; cpu_readdatavalid = 0;
  - cpu_wp_err = 0; jtag_cmd_err = 0; ram_wren = 0;
  - cpu_waitrequest = 1 while reset is high.
- Reset mid-operation aborts the operation: no RAM write, no readdatavalid.

JTAG command decode (sampled on the strobe cycle):
- take_action_ocimem_a: jtag_addr <= jdo[17 +: ADDR_W] immediately. If jdo[34]=1, also queue READ.
- take_no_action_ocimem_a: queue READ at jtag_addr.
- take_action_ocimem_b: queue WRITE with data jdo[34:3], byteenable 4'hF.
- More than one strobe in the same cycle: priority b > a > no_action_a. Lower-priority strobes are dropped and jtag_cmd_err is set.
- Any strobe while the pending slot is full, or state is not IDLE: the command (including its address load) is dropped and jtag_cmd_err is set.
- jtag_cmd_err clears only on reset.

FSM states: IDLE, JTAG_RD, CPU_RD.

IDLE:
- Pending JTAG WRITE: ram_wren=1 and ram_addr=jtag_addr this cycle; MonDReg <= write data; jtag_addr += 1; slot cleared; stay in IDLE.
- Pending JTAG READ: ram_addr=jtag_addr; go to JTAG_RD.
- No pending command and cpu_read|cpu_write: cpu_waitrequest=0 (combinational).
  - Write: ram_wren=1 with cpu byteenable and data; stay in IDLE.
  - Read: ram_addr=cpu_address; go to CPU_RD.
- cpu_read and cpu_write both high: treated as a read.

JTAG_RD:
- MonDReg <= ram_rdata; jtag_addr += 1; slot cleared; go to IDLE.

CPU_RD:
- cpu_readdata <= ram_rdata; cpu_readdatavalid=1 on the next cycle; go to IDLE.

cpu_waitrequest:
- Equals 1 except in IDLE with the slot empty and not in reset.
- A JTAG command queued in the same cycle as a CPU request does not stall that cycle's CPU grant; the JTAG command is serviced next cycle.

Latency and arbitration:
- JTAG write: 1 cycle from service.
- JTAG read: MonDReg updated 2 cycles after service.
- CPU read: readdatavalid 2 cycles after the request is accepted.
- Fixed JTAG priority; a CPU stall lasts at most 2 cycles per JTAG command.

Address arithmetic:
- jtag_addr increments modulo 2^ADDR_W; max wraps to 0.
- Address field bits of jdo above ADDR_W are ignored.

Optional Feature:
- Macro OCIMEM_CPU_WP_EN.
- Defined: a CPU write with cpu_address >= WP_BASE is accepted (waitrequest=0) but ram_wren stays 0, and cpu_wp_err pulses for 1 cycle. JTAG writes are never protected.
- Undefined: all CPU writes proceed; cpu_wp_err tied to 0; WP_BASE unused.

Test Plan:
1. Reset, then take_action_ocimem_a with jdo[17+:8]=8'h10 and jdo[34]=0, then take_action_ocimem_b with data 32'hDEADBEEF -> one cycle with ram_wren=1 at ram_addr=8'h10; MonDReg=32'hDEADBEEF; jtag_addr=8'h11.
2. Load address 8'hFF, write 32'h1, then take_no_action_ocimem_a -> write lands at 8'hFF; the read is issued at 8'h00 (wrap); MonDReg=RAM[0] two cycles after service; jtag_addr=8'h01.
3. CPU read of 8'h20 held high, with take_action_ocimem_b pulsed in the same cycle -> CPU granted that cycle; JTAG write serviced next cycle; cpu_readdatavalid 2 cycles after accept with RAM[8'h20].
4. take_action_ocimem_b and take_no_action_ocimem_a in the same cycle, then a second strobe while the slot is busy -> only the write executes; jtag_cmd_err=1 and stays set until reset.
5. Reset asserted in JTAG_RD -> MonDReg=0, state IDLE, no readdatavalid; cpu_waitrequest=1 during reset and 0 the first cycle after release if the CPU requests.
6. With OCIMEM_CPU_WP_EN: CPU write of 32'h5 to 8'hC4 -> no ram_wren; cpu_wp_err pulses once. Without the macro: write lands and cpu_wp_err=0.

Source files
------------

// File: rtl/nios2_ocimem_arbiter.sv
// Nios II OCI debug-memory controller: shares a single-port RAM between JTAG debug commands
// (fixed priority) and the CPU Avalon-MM slave. Optional CPU write protection: OCIMEM_CPU_WP_EN.
module nios2_ocimem_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned WP_BASE = 'hC0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic              cpu_waitrequest,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic              cpu_wp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              jtag_cmd_err
);

  typedef enum logic [1:0] {IDLE, JTAG_RD, CPU_RD} state_t;

`ifdef OCIMEM_CPU_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] jtag_addr_q;
  logic              pend_valid_q, pend_wr_q;
  logic [31:0]       pend_data_q;
  logic              wp_err_q;
  logic              svc_wr, cpu_go, cpu_wr_go, wp_block, jtag_done;
  logic              slot_free, any_strobe, multi_strobe;
  logic              unused_jdo;

  assign unused_jdo   = ^{jdo[37:35], jdo[2:0]};
  assign slot_free    = (state_q == IDLE) && !pend_valid_q;
  assign any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign multi_strobe = (take_action_ocimem_b & (take_action_ocimem_a | take_no_action_ocimem_a))
                      | (take_action_ocimem_a & take_no_action_ocimem_a);

  assign wp_block        = WP_EN && (32'(cpu_address) >= WP_BASE);
  assign cpu_wr_go       = cpu_go && !cpu_read;
  assign cpu_wp_err      = wp_err_q;
  assign cpu_waitrequest = reset || (state_q != IDLE) || pend_valid_q;
  assign jtag_done       = svc_wr || (state_q == JTAG_RD);

  // CPU_RD leaves the port idle (the read was issued last cycle), so a pending
  // JTAG command may be started there without waiting for IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state_q;
    ram_addr   = jtag_addr_q;
    ram_wren   = 1'b0;
    ram_byteen = 4'hF;
    ram_wdata  = pend_data_q;
    svc_wr     = 1'b0;
    cpu_go     = 1'b0;
    unique case (state_q)
      IDLE, CPU_RD: begin
        if (pend_valid_q) begin
          if (pend_wr_q) begin
            ram_wren = 1'b1;
            svc_wr   = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = JTAG_RD;
          end
        end else if (state_q == CPU_RD) begin
          state_d = IDLE;
        end else if (cpu_read || cpu_write) begin
          cpu_go   = 1'b1;
          ram_addr = cpu_address;
          if (cpu_read) begin
            state_d = CPU_RD;
          end else begin
            ram_wren   = !wp_block;
            ram_byteen = cpu_byteenable;
            ram_wdata  = cpu_writedata;
          end
        end
      end
      JTAG_RD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) begin
      ram_wren = 1'b0;
      cpu_go   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      jtag_addr_q       <= '0;
      pend_valid_q      <= 1'b0;
      MonDReg           <= '0;
      cpu_readdata      <= '0;
      cpu_readdatavalid <= 1'b0;
      wp_err_q          <= 1'b0;
      jtag_cmd_err      <= 1'b0;
    end else begin
      // NOTE: pend_wr_q/pend_data_q are left out of reset; pend_valid_q qualifies them.
      state_q           <= state_d;
      cpu_readdatavalid <= (state_q == CPU_RD);
      if (state_q == CPU_RD) cpu_readdata <= ram_rdata;
      wp_err_q <= cpu_wr_go && wp_block;

      if (jtag_done) begin
        pend_valid_q <= 1'b0;
        jtag_addr_q  <= jtag_addr_q + ADDR_W'(1);
        MonDReg      <= (state_q == JTAG_RD) ? ram_rdata : pend_data_q;
      end

      // Command intake only when idle with an empty slot; never overlaps jtag_done.
      if (any_strobe) begin
        if (!slot_free || multi_strobe) jtag_cmd_err <= 1'b1;
        if (slot_free) begin
          if (take_action_ocimem_b) begin
            pend_valid_q <= 1'b1;
            pend_wr_q    <= 1'b1;
            pend_data_q  <= jdo[34:3];
          end else if (take_action_ocimem_a) begin
            jtag_addr_q <= jdo[17 +: ADDR_W];
            if (jdo[34]) begin
              pend_valid_q <= 1'b1;
              pend_wr_q    <= 1'b0;
            end
          end else begin
            pend_valid_q <= 1'b1;
            pend_wr_q    <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Self-checking bench for nios2_ocimem_arbiter: directed scenarios plus randomized JTAG/CPU
// traffic checked against a word-level memory model. Honors OCIMEM_CPU_WP_EN if defined.
module tb_nios2_ocimem_arbiter;

`ifdef OCIMEM_CPU_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_waitrequest, cpu_readdatavalid, cpu_wp_err;
  logic [31:0] cpu_readdata;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata, ram_rdata, MonDReg;
  logic        jtag_cmd_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nios2_ocimem_arbiter #(.ADDR_W(8), .WP_BASE('hC0)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid), .cpu_wp_err(cpu_wp_err),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .MonDReg(MonDReg),
    .jtag_cmd_err(jtag_cmd_err)
  );

  // Environment RAM: single port, 1-cycle read latency, byte-enabled writes.
  logic [31:0] mem [256];
  bit          written [256];

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] env_word(input logic [7:0] a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_addr]     <= merge(env_word(ram_addr), ram_wdata, ram_byteen);
      written[ram_addr] <= 1'b1;
    end
    ram_rdata <= env_word(ram_addr);
  end

  // Reference model: intended memory contents and the JTAG address pointer.
  logic [31:0] ref_mem [256];
  int          ref_addr;

  function automatic logic [37:0] jdo_addr(input logic [8:0] hi, input logic [7:0] a, input bit rd);
    logic [37:0] j;
    j = '0;
    j[17 +: 8] = a;
    j[25 +: 9] = hi;
    j[34]      = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic drive_idle();
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0; jdo = '0;
  endtask

  // Strobes for one cycle; returns #1 after the following negedge.
  task automatic pulse(input bit a, input bit n, input bit b, input logic [37:0] j);
    take_action_ocimem_a = a; take_no_action_ocimem_a = n; take_action_ocimem_b = b; jdo = j;
    @(negedge clk);
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    jdo = '0;
    #1;
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [31:0] d, output bit got);
    got = 1'b0;
    d = 'x;
    cpu_address = a;
    cpu_read = 1'b1;
    #1;
    for (int k = 0; k < 8 && cpu_waitrequest; k++) begin @(negedge clk); #1; end
    @(negedge clk);
    cpu_read = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if (cpu_readdatavalid) begin got = 1'b1; d = cpu_readdata; end
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; drive_idle();
    cpu_read = 1'b1; cpu_address = 8'h33; cpu_writedata = '0; cpu_byteenable = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq: got %b want 1", cpu_waitrequest); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", ram_wren); end
    checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL rst_mondreg: got %h want 0", MonDReg); end
    checks++; if ({cpu_readdata, cpu_readdatavalid} !== 33'h0) begin errors++; $display("FAIL rst_rdata: got %h/%b want 0/0", cpu_readdata, cpu_readdatavalid); end
    checks++; if ({jtag_cmd_err, cpu_wp_err} !== 2'b00) begin errors++; $display("FAIL rst_errs: got %b%b want 00", jtag_cmd_err, cpu_wp_err); end
    cpu_read = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_release_waitreq: got %b want 0", cpu_waitrequest); end
    ref_addr = 0;
    @(negedge clk); #1;
  endtask

  task automatic test_jtag_write();
    pulse(1'b1, 1'b0, 1'b0, jdo_addr(9'h0, 8'h10, 1'b0));
    ref_addr = 'h10;
    pulse(1'b0, 1'b0, 1'b1, jdo_data(32'hDEADBEEF));
    checks++; if ({ram_wren, ram_addr} !== {1'b1, 8'h10}) begin errors++; $display("FAIL jw_issue: got wren=%b addr=%h want 1/10", ram_wren, ram_addr); end
    checks++; if ({ram_wdata, ram_byteen} !== {32'hDEADBEEF, 4'hF}) begin errors++; $display("FAIL jw_data: got %h/%h want deadbeef/f", ram_wdata, ram_byteen); end
    checks++; if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL jw_stall: got %b want 1", cpu_waitrequest); end
    ref_mem['h10] = 32'hDEADBEEF;
    ref_addr = 'h11;
    @(negedge clk); #1;
    checks++; if ({ram_wren, MonDReg} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL jw_mondreg: got wren=%b mon=%h want 0/deadbeef", ram_wren, MonDReg); end
    pulse(1'b0, 1'b1, 1'b0, '0);
    checks++; if ({ram_wren, ram_addr} !== {1'b0, 8'h11}) begin errors++; $display("FAIL jw_nextaddr: got wren=%b addr=%h want 0/11", ram_wren, ram_addr); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (MonDReg !== ref_mem['h11]) begin errors++; $display("FAIL jw_readback: got %h want %h", MonDReg, ref_mem['h11]); end
    ref_addr = 'h12;
  endtask

  task automatic test_wrap_read();
    pulse(1'b1, 1'b0, 1'b0, jdo_addr(9'h0, 8'hFF, 1'b0));
    pulse(1'b0, 1'b0, 1'b1, jdo_data(32'h1));
    checks++; if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, 8'hFF, 32'h1}) begin errors++; $display("FAIL wrap_write: got %b/%h/%h want 1/ff/1", ram_wren, ram_addr, ram_wdata); end
    ref_mem['hFF] = 32'h1;
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      pulse(1'b0, 1'b1, 1'b0, '0);
      checks++; if (ram_addr !== 8'(i)) begin errors++; $display("FAIL wrap_rdaddr%0d: got %h want %h", i, ram_addr, 8'(i)); end
      repeat (2) @(negedge clk);
      #1;
      checks++; if (MonDReg !== ref_mem[i]) begin errors++; $display("FAIL wrap_rddata%0d: got %h want %h", i, MonDReg, ref_mem[i]); end
    end
    ref_addr = 2;
  endtask

  task automatic test_cpu_jtag_same_cycle();
    pulse(1'b1, 1'b0, 1'b0, jdo_addr(9'h0, 8'h40, 1'b0));
    cpu_address = 8'h20; cpu_read = 1'b1;
    take_action_ocimem_b = 1'b1; jdo = jdo_data(32'h12345678);
    #1;
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL cj_grant: got %b want 0", cpu_waitrequest); end
    @(negedge clk);
    cpu_read = 1'b0; take_action_ocimem_b = 1'b0; jdo = '0;
    #1;
    checks++; if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, 8'h40, 32'h12345678}) begin errors++; $display("FAIL cj_jwrite: got %b/%h/%h want 1/40/12345678", ram_wren, ram_addr, ram_wdata); end
    checks++; if ({cpu_waitrequest, cpu_readdatavalid} !== 2'b10) begin errors++; $display("FAIL cj_midcycle: got wr=%b rdv=%b want 1/0", cpu_waitrequest, cpu_readdatavalid); end
    ref_mem['h40] = 32'h12345678;
    ref_addr = 'h41;
    @(negedge clk); #1;
    checks++; if ({cpu_readdatavalid, cpu_readdata} !== {1'b1, ref_mem['h20]}) begin errors++; $display("FAIL cj_rdata: got %b/%h want 1/%h", cpu_readdatavalid, cpu_readdata, ref_mem['h20]); end
    checks++; if (MonDReg !== 32'h12345678) begin errors++; $display("FAIL cj_mondreg: got %h want 12345678", MonDReg); end
    @(negedge clk); #1;
    checks++; if (cpu_readdatavalid !== 1'b0) begin errors++; $display("FAIL cj_rdv_pulse: got %b want 0", cpu_readdatavalid); end
  endtask

  task automatic test_cmd_err();
    checks++; if (jtag_cmd_err !== 1'b0) begin errors++; $display("FAIL ce_initial: got %b want 0", jtag_cmd_err); end
    pulse(1'b0, 1'b1, 1'b1, jdo_data(32'hCAFEF00D));
    checks++; if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, 8'(ref_addr), 32'hCAFEF00D}) begin errors++; $display("FAIL ce_write: got %b/%h/%h want 1/%h/cafef00d", ram_wren, ram_addr, ram_wdata, 8'(ref_addr)); end
    checks++; if (jtag_cmd_err !== 1'b1) begin errors++; $display("FAIL ce_set: got %b want 1", jtag_cmd_err); end
    ref_mem[ref_addr] = 32'hCAFEF00D;
    ref_addr = (ref_addr + 1) % 256;
    pulse(1'b0, 1'b1, 1'b0, '0);
    checks++; if ({ram_wren, cpu_waitrequest} !== 2'b00) begin errors++; $display("FAIL ce_dropped: got wren=%b wr=%b want 0/0", ram_wren, cpu_waitrequest); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({jtag_cmd_err, MonDReg} !== {1'b1, 32'hCAFEF00D}) begin errors++; $display("FAIL ce_sticky: got %b/%h want 1/cafef00d", jtag_cmd_err, MonDReg); end
  endtask

  task automatic test_reset_midop();
    pulse(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    reset = 1'b1; cpu_read = 1'b1; cpu_address = 8'h05;
    #1;
    checks++; if ({cpu_waitrequest, ram_wren} !== 2'b10) begin errors++; $display("FAIL rm_inreset: got wr=%b wren=%b want 1/0", cpu_waitrequest, ram_wren); end
    @(negedge clk); #1;
    checks++; if ({MonDReg, cpu_readdatavalid, jtag_cmd_err} !== 34'h0) begin errors++; $display("FAIL rm_cleared: got %h/%b/%b want 0/0/0", MonDReg, cpu_readdatavalid, jtag_cmd_err); end
    reset = 1'b0;
    ref_addr = 0;
    #1;
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL rm_release: got %b want 0", cpu_waitrequest); end
    @(negedge clk);
    cpu_read = 1'b0;
    #1;
    checks++; if (cpu_readdatavalid !== 1'b0) begin errors++; $display("FAIL rm_early_rdv: got %b want 0", cpu_readdatavalid); end
    @(negedge clk); #1;
    checks++; if ({cpu_readdatavalid, cpu_readdata} !== {1'b1, ref_mem[5]}) begin errors++; $display("FAIL rm_cpuread: got %b/%h want 1/%h", cpu_readdatavalid, cpu_readdata, ref_mem[5]); end
    @(negedge clk); #1;
  endtask

  task automatic test_cpu_write_protect();
    logic [31:0] d;
    bit          got;
    cpu_address = 8'hC4; cpu_writedata = 32'h5; cpu_byteenable = 4'hF; cpu_write = 1'b1;
    #1;
    checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL wp_accept: got %b want 0", cpu_waitrequest); end
    checks++; if (ram_wren !== !WP_EN) begin errors++; $display("FAIL wp_wren: got %b want %b", ram_wren, !WP_EN); end
    if (!WP_EN) ref_mem['hC4] = 32'h5;
    @(negedge clk);
    cpu_write = 1'b0;
    #1;
    checks++; if (cpu_wp_err !== WP_EN) begin errors++; $display("FAIL wp_err_pulse: got %b want %b", cpu_wp_err, WP_EN); end
    @(negedge clk); #1;
    checks++; if (cpu_wp_err !== 1'b0) begin errors++; $display("FAIL wp_err_clear: got %b want 0", cpu_wp_err); end
    cpu_rd(8'hC4, d, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL wp_readback_timeout: got no readdatavalid want one"); end
    checks++; if (d !== ref_mem['hC4]) begin errors++; $display("FAIL wp_readback: got %h want %h", d, ref_mem['hC4]); end
  endtask

  task automatic test_random();
    logic [31:0] d, got_d;
    logic [7:0]  a;
    logic [3:0]  be;
    bit          got, do_read;
    int          op, k;
    for (int it = 0; it < 120; it++) begin
      op = $urandom_range(0, 4);
      do_read = 1'b0;
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      case (op)
        0: begin
          do_read = 1'($urandom_range(0, 1));
          pulse(1'b1, 1'b0, 1'b0, jdo_addr(9'($urandom_range(0, 511)), a, do_read));
          ref_addr = a;
        end
        1: begin
          do_read = 1'b1;
          pulse(1'b0, 1'b1, 1'b0, '0);
        end
        2: begin
          pulse(1'b0, 1'b0, 1'b1, jdo_data(d));
          checks++; if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, 8'(ref_addr), d}) begin errors++; $display("FAIL rnd_jwrite it=%0d: got %b/%h/%h want 1/%h/%h", it, ram_wren, ram_addr, ram_wdata, 8'(ref_addr), d); end
          ref_mem[ref_addr] = d;
          ref_addr = (ref_addr + 1) % 256;
          @(negedge clk); #1;
          checks++; if (MonDReg !== d) begin errors++; $display("FAIL rnd_jwmon it=%0d: got %h want %h", it, MonDReg, d); end
        end
        3: begin
          cpu_rd(a, got_d, got);
          checks++; if ({got, got_d} !== {1'b1, ref_mem[a]}) begin errors++; $display("FAIL rnd_cpurd it=%0d addr=%h: got %b/%h want 1/%h", it, a, got, got_d, ref_mem[a]); end
        end
        default: begin
          be = 4'($urandom_range(1, 15));
          cpu_address = a; cpu_writedata = d; cpu_byteenable = be; cpu_write = 1'b1;
          #1;
          for (k = 0; k < 8 && cpu_waitrequest; k++) begin @(negedge clk); #1; end
          checks++; if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL rnd_cpuwr_timeout it=%0d: waitrequest stuck at %b", it, cpu_waitrequest); end
          if (!(WP_EN && a >= 8'hC0)) ref_mem[a] = merge(ref_mem[a], d, be);
          @(negedge clk);
          cpu_write = 1'b0;
          #1;
        end
      endcase
      if (do_read) begin
        checks++; if ({ram_wren, ram_addr} !== {1'b0, 8'(ref_addr)}) begin errors++; $display("FAIL rnd_rdaddr it=%0d: got %b/%h want 0/%h", it, ram_wren, ram_addr, 8'(ref_addr)); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (MonDReg !== ref_mem[ref_addr]) begin errors++; $display("FAIL rnd_rddata it=%0d: got %h want %h", it, MonDReg, ref_mem[ref_addr]); end
        ref_addr = (ref_addr + 1) % 256;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    void'($urandom(32'h0C1_0001));
    test_reset();
    test_jtag_write();
    test_wrap_read();
    test_cpu_jtag_same_cycle();
    test_cmd_err();
    test_reset_midop();
    test_cpu_write_protect();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
